// File: rtl/spi_responder.sv
// spi_responder: SPI byte-stream to 8-bit bus bridge; define SPI_RESPONDER_STATUS_EN to enable the 0x05 status command
module spi_responder #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic [7:0]            mosi,
    output logic                  ready,
    output logic [7:0]            miso,
    output logic                  miso_valid,
    output logic                  bus_valid,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wdata,
    input  logic                  bus_ready,
    input  logic [7:0]            bus_rdata
);
    localparam int ADDR_BYTES = ADDR_WIDTH / 8;
    typedef enum logic [2:0] {CMD, ADDR, DATA, BUS, DISCARD, STATUS} state_t;
    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  abort_q, abort_d;
    logic [7:0]            miso_q, miso_d;
    logic                  miso_valid_q, miso_valid_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [7:0]            bus_wdata_q, bus_wdata_d;
`ifdef SPI_RESPONDER_STATUS_EN
    logic [7:0]            wr_cnt_q, wr_cnt_d;
`endif
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        abort_d      = abort_q;
        miso_d       = miso_q;
        miso_valid_d = miso_valid_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
`ifdef SPI_RESPONDER_STATUS_EN
        wr_cnt_d     = wr_cnt_q + 8'((state_q == BUS) && bus_ready && bus_we_q);
`endif
        // Outside BUS a low cs always means a byte is accepted this cycle
        if (cs && state_q != BUS) begin
            state_d      = CMD;
            miso_valid_d = 1'b0;
        end else begin
            case (state_q)
                CMD: begin
                    cnt_d = 2'd0;
                    if (mosi == 8'h02 || mosi == 8'h03) begin
                        bus_we_d = ~mosi[0];
                        state_d  = ADDR;
                    end
`ifdef SPI_RESPONDER_STATUS_EN
                    else if (mosi == 8'h05) begin
                        miso_d       = wr_cnt_q;
                        miso_valid_d = 1'b1;
                        state_d      = STATUS;
                    end
`endif
                    else state_d = DISCARD;
                end
                ADDR: begin
                    bus_addr_d = ADDR_WIDTH'({bus_addr_q, mosi});
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'(ADDR_BYTES - 1)) state_d = bus_we_q ? DATA : BUS;
                end
                DATA: begin
                    if (bus_we_q) bus_wdata_d = mosi;
                    else begin
                        miso_valid_d = 1'b0;
                        bus_addr_d   = bus_addr_q + 1'b1;
                    end
                    state_d = BUS;
                end
                BUS: begin
                    abort_d = abort_q | cs;
                    if (bus_ready) begin
                        abort_d = 1'b0;
                        if (bus_we_q) bus_addr_d = bus_addr_q + 1'b1;
                        else if (!(abort_q || cs)) begin
                            miso_d       = bus_rdata;
                            miso_valid_d = 1'b1;
                        end
                        state_d = (abort_q || cs) ? CMD : DATA;
                    end
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CMD;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            miso_q       <= '0;
            miso_valid_q <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
`ifdef SPI_RESPONDER_STATUS_EN
            wr_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            miso_q       <= miso_d;
            miso_valid_q <= miso_valid_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
`ifdef SPI_RESPONDER_STATUS_EN
            wr_cnt_q     <= wr_cnt_d;
`endif
        end
    end
    assign ready      = state_q != BUS;
    assign bus_valid  = state_q == BUS;
    assign miso       = miso_q;
    assign miso_valid = miso_valid_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
endmodule
